// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and helpers for the interrupt controller
//
// Purpose: FSM state encoding, trigger-mode constants and a constant-foldable
//          clog2 used to size the cause ID.
// Ports:   none (package).

package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// rtl/intc_sync_edge.sv - per-source synchroniser and edge/level event detector
//
// Purpose: brings one asynchronous source into the clock domain through a
//          SYNC_STAGES flop chain and reports an event either on a rising
//          edge or while the source is high, depending on mode_i.
// Ports:
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   src_i    - raw asynchronous source
//   mode_i   - 1 = rising-edge triggered, 0 = level (active-high)
//   event_o  - combinational event for the pending register

module intc_sync_edge
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic mode_i,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= sync_s;
    end
  end

  // Mode is sampled combinationally so a change applies at the very next edge.
  assign event_o = (mode_i == MODE_EDGE) ? (sync_s & ~prev_q) : sync_s;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - multi-source interrupt controller with ACK/EOI handshake
//
// Purpose: synchronises NUM_SRC sources, latches events into a pending
//          register, masks and fixed-priority encodes them (lowest index
//          wins) and drives a single registered IRQ with an ACK/EOI handshake.
// Ports:
//   CLK     - system clock, rising edge
//   Reset   - synchronous active-high reset
//   Src     - raw asynchronous sources
//   Mode    - per source: 1 = rising edge, 0 = level
//   Enable  - per-source mask for raising IRQ
//   CLR     - per-source pending clear strobe
//   IRQ     - registered interrupt request
//   Cause   - registered index of the requested/serviced source
//   Ack     - CPU accepts the request (honoured only in REQ)
//   EOI     - end of service (honoured only in SERVICE)
//   Busy    - high while in SERVICE
//   State   - pending register, for debug display

module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = clog2(NUM_SRC)
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] Src,
  input  logic [NUM_SRC-1:0] Mode,
  input  logic [NUM_SRC-1:0] Enable,
  input  logic [NUM_SRC-1:0] CLR,
  output logic               IRQ,
  output logic [ID_W-1:0]    Cause,
  input  logic               Ack,
  input  logic               EOI,
  output logic               Busy,
  output logic [NUM_SRC-1:0] State
);

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               cause_eligible;
  logic               ack_take;

  intc_state_e        state_q;
  logic               irq_q;
  logic               busy_q;
  logic [ID_W-1:0]    cause_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i  (CLK),
      .rst_i  (Reset),
      .src_i  (Src[g]),
      .mode_i (Mode[g]),
      .event_o(evt[g])
    );
  end

  assign ack_take = (state_q == ST_REQ) && Ack;
  assign eligible = pend_q & Enable;

  // Clear vector folds the accepted cause into the software clears.
  always_comb begin
    clr_vec        = '0;
    cause_eligible = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_vec[i] = CLR[i] | (ack_take && (cause_q == ID_W'(i)));
      if (cause_q == ID_W'(i)) cause_eligible = eligible[i];
    end
  end

  // Set dominates clear so an event coinciding with a clear is never lost.
  assign pend_d = (pend_q & ~clr_vec) | evt;

  // Scan from the top down so the lowest eligible index is the last to write.
  always_comb begin
    win_id    = '0;
    win_valid = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            cause_q <= win_id;
            irq_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Cause stays frozen here; a higher-priority arrival waits its turn.
          if (Ack) begin
            irq_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SERVICE;
          end else if (!cause_eligible) begin
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (EOI) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign IRQ   = irq_q;
  assign Cause = cause_q;
  assign Busy  = busy_q;
  assign State = pend_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Parametrised successor to the button/switch interrupt register. Takes NUM_SRC asynchronous interrupt sources and synchronises each one. Each source is edge- or level-detected according to its own mode bit, latched into a pending register, masked, and priority-encoded. A single IRQ line with an ACK/EOI handshake goes to the processor control unit, and the raw pending vector is exported for debug display.

Parameters:
NUM_SRC, 8, number of interrupt sources (2..32)
SYNC_STAGES, 2, synchroniser flops per source (>=2)
ID_W, $clog2(NUM_SRC), width of the cause ID

Ports:
CLK  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Src  input  NUM_SRC  raw asynchronous interrupt sources (buttons, switches)
Mode  input  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level (active-high)
Enable  input  NUM_SRC  per-source mask; 1 = may raise IRQ
CLR  input  NUM_SRC  per-source pending clear, one-cycle strobe
IRQ  output  1  interrupt request to the CPU (registered)
Cause  output  ID_W  index of the source being requested/serviced (registered)
Ack  input  1  CPU accepts the request; one-cycle strobe
EOI  input  1  end of interrupt service; one-cycle strobe
Busy  output  1  1 while in SERVICE
State  output  NUM_SRC  pending register, for debug/LED display

Behaviour:
- Reset (synchronous, on a CLK edge with Reset=1):
  - clears the synchroniser chains, the edge-history flops and the pending register.
  - forces the FSM to IDLE, so IRQ=0, Cause=0, Busy=0, State=0.
  - Reset asserted mid-handshake abandons the handshake; no pending state survives.
- Synchronisation: Src[i] passes through SYNC_STAGES flops, giving s[i]; prev[i] holds the previous s[i].
- Event detection:
  - Mode[i]=1: event when s[i] & ~prev[i].
  - Mode[i]=0: event while s[i]=1.
  - Mode changes take effect on the next edge.
- Pending update, per bit each cycle: pend_next = (pend & ~clr_i) | event.
  - clr_i = CLR[i] | (Ack accepted in REQ & Cause==i).
  - Set wins over clear in the same cycle, so no event is lost.
  - In level mode, a clear while the source is still high is re-set immediately.
- Disabling a source does not clear its pending bit, and pending still latches while masked. Re-enabling a source with its bit still pending raises IRQ.
- Latency (SYNC_STAGES=2): Src rises before edge 0 → s at edge 1 → pending set at edge 2 → IRQ=1 after edge 3.
- Priority: eligible = pending & Enable; the lowest index wins, fixed priority.
- FSM states:
  - IDLE: if eligible != 0, latch Cause = winner, set IRQ=1, go to REQ.
  - REQ: IRQ=1 and Cause is held stable, even if a higher-priority source arrives.
    - Ack=1: clear pend[Cause], IRQ=0, Busy=1, go to SERVICE.
    - Otherwise, if eligible[Cause]=0 (cleared or masked before Ack): IRQ=0, go to IDLE (request withdrawn).
  - SERVICE: Busy=1 and no new IRQ; pending keeps accumulating.
    - EOI=1: Busy=0, go to IDLE. A new request can follow on the next edge.
- Ignored strobes: Ack outside REQ, EOI outside SERVICE.
- Ack and EOI in the same cycle in REQ: Ack is processed and EOI is ignored.
- Cause holds its value in IDLE until the next request is latched.

Decomposition:
- Package intc_pkg:
  - FSM state typedef (IDLE, REQ, SERVICE), 2-bit encoding.
  - MODE_LEVEL/MODE_EDGE constants.
  - clog2 helper function.
- Sub-module intc_sync_edge: one per source via generate. Contains the SYNC_STAGES chain, the prev flop and Mode select, and outputs the event bit.
- Priority encoder and FSM stay in the top level.

Test Plan:
1. Reset then idle (NUM_SRC=8, all Enable=1, Src=0) → State=0x00, IRQ=0, Cause=0, Busy=0 for 10 cycles.
2. Edge source: Mode=0xFF, pulse Src[3] for 1 cycle → State=0x08 two edges after sync, IRQ=1 next edge with Cause=3. Ack → IRQ=0, Busy=1, State=0x00. EOI → Busy=0.
3. Priority/hold: Src[5] then Src[2] rises while in REQ(Cause=5) → Cause stays 5. After Ack+EOI: IRQ=1, Cause=2.
4. Level source: Mode[1]=0, Src[1] held high, CLR=0x02 → State[1] stays 1. Drop Src[1] then CLR=0x02 → State[1]=0.
5. Withdrawal: pending[4] in REQ, Enable[4]=0 before Ack → IRQ=0 next edge, FSM IDLE, State[4] still 1. Re-enable → IRQ=1, Cause=4.
6. Simultaneous set/clear plus reset: CLR[0] coincident with a new edge on Src[0] → State[0]=1. Reset asserted in SERVICE → all outputs 0 on the next edge.
